arm_source_mux: RTL and testbench



---
 rtl/arm_source_mux_pkg.sv | 29 ++
 rtl/arm_source_mux_if.sv | 44 ++++
 rtl/arm_source_mux_btn_debounce.sv | 51 +++++
 rtl/arm_source_mux.sv | 109 ++++++++++
 tb/tb_arm_source_mux.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/arm_source_mux_pkg.sv
// Shared state/mode encoding for the arm set-point source selector.
// The display/LED logic decodes the same constants from the mode output.
package arm_src_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCEL  = 2'd1;
    localparam state_t ST_MEM    = 2'd2;
    localparam state_t ST_UNUSED = 2'd3;

    localparam logic [1:0] MODE_IDLE  = 2'd0;
    localparam logic [1:0] MODE_ACCEL = 2'd1;
    localparam logic [1:0] MODE_MEM   = 2'd2;

    // The next state depends only on the inputs, so an illegal encoding falls back on its own.
    function automatic state_t next_state(input logic enable, input logic btn_db);
        state_t ns;
        if (!enable) begin
            ns = ST_IDLE;
        end else if (btn_db) begin
            ns = ST_MEM;
        end else begin
            ns = ST_ACCEL;
        end
        return ns;
    endfunction

endpackage

// File: rtl/arm_source_mux_if.sv
// Bus between the accelerometer/ROM front end, the source mux and the servo PWM side.
// The mux itself connects through the slave modport.
interface arm_source_mux_if #(
    parameter int W      = 8,
    parameter int N_AXES = 3,
    parameter int ADDR_W = 4
);
    import arm_src_pkg::*;

    logic                  enable;
    logic                  btn_mem;
    logic                  tick;
    logic [N_AXES*W-1:0]   accel_data;
    logic [N_AXES*W-1:0]   rom_data;
    logic [ADDR_W-1:0]     rom_addr;
    logic [N_AXES*W-1:0]   data_out;
    logic                  out_valid;
    state_t                mode;

    modport master (
        output enable,
        output btn_mem,
        output tick,
        output accel_data,
        output rom_data,
        input  rom_addr,
        input  data_out,
        input  out_valid,
        input  mode
    );

    modport slave (
        input  enable,
        input  btn_mem,
        input  tick,
        input  accel_data,
        input  rom_data,
        output rom_addr,
        output data_out,
        output out_valid,
        output mode
    );

endinterface

// File: rtl/arm_source_mux_btn_debounce.sv
// Two-flop synchroniser plus stability counter for the raw memory-mode button.
// btn_db only follows the synced level after DEBOUNCE_CYC consecutive cycles of it.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_async,
    output logic btn_db
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;

    // The counter only runs while the synced level disagrees with btn_db; agreement clears it.
    always_comb begin
        sync1_d = btn_async;
        sync2_d = sync1_q;
        cnt_d   = '0;
        db_d    = db_q;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            db_q    <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
        end
    end

    assign btn_db = db_q;

endmodule

// File: rtl/arm_source_mux.sv
// Selects home pose, live accel or ROM playback as the servo target and slews
// the registered set-points towards it by at most STEP per tick.
module arm_source_mux
    import arm_src_pkg::*;
#(
    parameter int W            = 8,
    parameter int N_AXES       = 3,
    parameter int HOME         = 10,
    parameter int STEP         = 4,
    parameter int DEPTH        = 16,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic               clk,
    input  logic               rst,
    arm_source_mux_if.slave    bus
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [W-1:0]        HOME_W    = W'(HOME);
    localparam logic [W-1:0]        STEP_W    = W'(STEP);
    localparam logic [N_AXES*W-1:0] HOME_VEC  = {N_AXES{HOME_W}};
    localparam logic [ADDR_W-1:0]   ADDR_LAST = ADDR_W'(DEPTH - 1);

    logic                 btn_db;
    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    rom_addr_q, rom_addr_d;
    logic [N_AXES*W-1:0]  data_out_q, data_out_d;
    logic                 out_valid_q, out_valid_d;
    logic [N_AXES*W-1:0]  target;
    logic [N_AXES*W-1:0]  data_next;

    btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_btn_debounce (
        .clk       (clk),
        .rst       (rst),
        .btn_async (bus.btn_mem),
        .btn_db    (btn_db)
    );

    always_comb begin
        state_d = next_state(bus.enable, btn_db);
    end

    // Target follows the registered state, so a tick during a transition still uses the old source.
    always_comb begin
        target = HOME_VEC;
        case (state_q)
            ST_ACCEL: target = bus.accel_data;
            ST_MEM:   target = bus.rom_data;
            default:  target = HOME_VEC;
        endcase
    end

    // Difference is taken one bit wider and signed so large moves in either direction never wrap.
    for (genvar g = 0; g < N_AXES; g++) begin : g_axis
        logic [W-1:0]   cur;
        logic [W-1:0]   tgt;
        logic signed [W:0] diff;
        logic [W:0]     mag;
        logic           direct;

        assign cur    = data_out_q[g*W +: W];
        assign tgt    = target[g*W +: W];
        assign diff   = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        assign mag    = diff[W] ? -diff : diff;
        assign direct = (STEP == 0) || (32'(mag) <= 32'(STEP));

        assign data_next[g*W +: W] = direct  ? tgt :
                                     diff[W] ? (cur - STEP_W) :
                                               (cur + STEP_W);
    end

    always_comb begin
        data_out_d  = bus.tick ? data_next : data_out_q;
        out_valid_d = bus.tick;
    end

    // Entry into playback always restarts at address 0, even if a tick lands in the same cycle.
    always_comb begin
        rom_addr_d = rom_addr_q;
        if ((state_d == ST_MEM) && (state_q != ST_MEM)) begin
            rom_addr_d = '0;
        end else if ((state_q == ST_MEM) && bus.tick) begin
            rom_addr_d = (rom_addr_q == ADDR_LAST) ? '0 : rom_addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rom_addr_q  <= '0;
            data_out_q  <= HOME_VEC;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.rom_addr  = rom_addr_q;
    assign bus.data_out  = data_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.mode      = state_q;

endmodule

// File: tb/tb_arm_source_mux.sv
// Directed bench for arm_source_mux: reset, slew, debounce, playback wrap,
// disable ramp-down and reset-versus-tick priority, against hand-computed values.
module tb_arm_source_mux;

    localparam int W            = 8;
    localparam int N_AXES       = 3;
    localparam int HOME         = 10;
    localparam int STEP         = 4;
    localparam int DEPTH        = 16;
    localparam int DEBOUNCE_CYC = 4;
    localparam int ADDR_W       = 4;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    arm_source_mux_if #(.W(W), .N_AXES(N_AXES), .ADDR_W(ADDR_W)) bus ();

    arm_source_mux #(
        .W            (W),
        .N_AXES       (N_AXES),
        .HOME         (HOME),
        .STEP         (STEP),
        .DEPTH        (DEPTH),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Registered ROM model: word = {z=20, y=10, x=30+addr}, valid one cycle after the address.
    always @(posedge clk) begin
        bus.rom_data <= {8'd20, 8'd10, 8'(30 + bus.rom_addr)};
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic en, input logic btn, input logic [23:0] accel);
        bus.enable     = en;
        bus.btn_mem    = btn;
        bus.accel_data = accel;
    endtask

    task automatic pulseTick();
        bus.tick = 1'b1;
        step(1);
        bus.tick = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int exp_x;
        int exp_z;

        // Reset with random inputs, including a tick.
        rst            = 1'b1;
        bus.enable     = 1'($urandom);
        bus.btn_mem    = 1'($urandom);
        bus.tick       = 1'($urandom);
        bus.accel_data = 24'($urandom);
        step(2);
        checkOutput("reset_data", 32'(bus.data_out), 32'({8'd10, 8'd10, 8'd10}));
        checkOutput("reset_mode", 32'(bus.mode), 32'd0);
        checkOutput("reset_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_addr", 32'(bus.rom_addr), 32'd0);

        // Slew up towards accel x=30.
        rst      = 1'b0;
        bus.tick = 1'b0;
        applyStimulus(1'b1, 1'b0, {8'd10, 8'd10, 8'd30});
        step(1);
        checkOutput("accel_mode", 32'(bus.mode), 32'd1);
        begin
            int slew_up [6] = '{14, 18, 22, 26, 30, 30};
            for (int i = 0; i < 6; i++) begin
                pulseTick();
                checkOutput($sformatf("slew_up_x%0d", i), 32'(bus.data_out[7:0]), 32'(slew_up[i]));
                checkOutput($sformatf("slew_up_valid%0d", i), 32'(bus.out_valid), 32'd1);
                step(1);
                checkOutput($sformatf("slew_up_valid_low%0d", i), 32'(bus.out_valid), 32'd0);
            end
        end
        checkOutput("slew_up_mode", 32'(bus.mode), 32'd1);

        // Three-cycle button glitch must be rejected.
        bus.btn_mem = 1'b1;
        step(3);
        bus.btn_mem = 1'b0;
        step(10);
        checkOutput("glitch_mode", 32'(bus.mode), 32'd1);

        // Held button: MEM exactly 7 cycles after the rising edge.
        bus.btn_mem = 1'b1;
        step(6);
        checkOutput("debounce_mode_early", 32'(bus.mode), 32'd1);
        step(1);
        checkOutput("debounce_mode", 32'(bus.mode), 32'd2);
        checkOutput("debounce_addr", 32'(bus.rom_addr), 32'd0);

        // Playback: 17 ticks wrap the address; x follows 30+addr, z ramps to 20.
        for (int i = 1; i <= 17; i++) begin
            pulseTick();
            exp_x = (i <= 16) ? (29 + i) : 41;
            exp_z = (i == 1) ? 14 : ((i == 2) ? 18 : 20);
            checkOutput($sformatf("play_addr%0d", i), 32'(bus.rom_addr), 32'(i % 16));
            checkOutput($sformatf("play_x%0d", i), 32'(bus.data_out[7:0]), 32'(exp_x));
            checkOutput($sformatf("play_z%0d", i), 32'(bus.data_out[23:16]), 32'(exp_z));
            step(1);
        end

        // Back to ACCEL and climb to x=100; the ROM address holds.
        bus.btn_mem = 1'b0;
        step(8);
        checkOutput("back_accel_mode", 32'(bus.mode), 32'd1);
        applyStimulus(1'b1, 1'b0, {8'd20, 8'd10, 8'd100});
        for (int i = 0; i < 15; i++) begin
            pulseTick();
            step(1);
        end
        checkOutput("climb_data", 32'(bus.data_out), 32'({8'd20, 8'd10, 8'd100}));
        checkOutput("addr_hold", 32'(bus.rom_addr), 32'd1);

        // Disable mid-motion: x ramps down by 4 and settles at HOME on tick 23.
        bus.enable = 1'b0;
        step(1);
        checkOutput("disable_mode", 32'(bus.mode), 32'd0);
        for (int i = 1; i <= 24; i++) begin
            pulseTick();
            exp_x = (i <= 22) ? (100 - 4 * i) : 10;
            checkOutput($sformatf("down_x%0d", i), 32'(bus.data_out[7:0]), 32'(exp_x));
            step(1);
        end
        checkOutput("down_data", 32'(bus.data_out), 32'({8'd10, 8'd10, 8'd10}));

        // Re-entry into MEM restarts at 0; then reset collides with a tick at addr 9.
        applyStimulus(1'b1, 1'b1, {8'd20, 8'd10, 8'd100});
        step(8);
        checkOutput("reenter_mode", 32'(bus.mode), 32'd2);
        checkOutput("reenter_addr", 32'(bus.rom_addr), 32'd0);
        for (int i = 0; i < 9; i++) begin
            pulseTick();
            step(1);
        end
        checkOutput("pre_rst_addr", 32'(bus.rom_addr), 32'd9);
        rst      = 1'b1;
        bus.tick = 1'b1;
        step(1);
        checkOutput("coll_addr", 32'(bus.rom_addr), 32'd0);
        checkOutput("coll_data", 32'(bus.data_out), 32'({8'd10, 8'd10, 8'd10}));
        checkOutput("coll_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("coll_mode", 32'(bus.mode), 32'd0);
        rst      = 1'b0;
        bus.tick = 1'b0;
        step(1);
        checkOutput("post_rst_mode", 32'(bus.mode), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
